// File: rtl/pipe_hazard_ctrl.sv
// In-order pipeline control for the 16-bit core.
// Keeps its own scoreboard of slots 2..STAGES-1, decides stalls, flushes,
// redirects and EX operand bypass, and counts stall and flush cycles.
module pipe_hazard_ctrl #(
   parameter int STAGES   = 5,
   parameter int RA_W     = 4,
   parameter int LOAD_LAT = 1,
   parameter int SEL_W    = 3
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             id_valid,
   input  logic [RA_W-1:0]  id_rs1,
   input  logic [RA_W-1:0]  id_rs2,
   input  logic             id_rs1_en,
   input  logic             id_rs2_en,
   input  logic [RA_W-1:0]  id_rd,
   input  logic             id_rd_en,
   input  logic             id_is_load,
   input  logic             redirect_ex,
   input  logic             redirect_mem,
   input  logic             mem_wait,
   output logic             pc_write,
   output logic [1:0]       pc_sel,
   output logic             ifid_write,
   output logic             flush_ifid,
   output logic             bubble,
   output logic             flush_ex,
   output logic [SEL_W-1:0] fwd_sel1,
   output logic [SEL_W-1:0] fwd_sel2,
   output logic [15:0]      stall_cnt,
   output logic [15:0]      flush_cnt
);

   // Scoreboard: index is the slot number (2 = ID/EX, 3.. = post-EX).
   logic            vld   [2:STAGES-1];
   logic [RA_W-1:0] rd    [2:STAGES-1];
   logic            rd_en [2:STAGES-1];
   logic            ld    [2:STAGES-1];

   // Source operands of the instruction currently in EX.
   logic [RA_W-1:0] rs1_p2;
   logic [RA_W-1:0] rs2_p2;
   logic            rs1_en_p2;
   logic            rs2_en_p2;

   logic [15:0]     stall_q;
   logic [15:0]     flush_q;

   logic            load_hit;
   logic            take_mem;
   logic            take_ex;
   logic            lu_stall;
   logic            bubble_i;
   logic            advance;
   logic [SEL_W-1:0] fsel1;
   logic [SEL_W-1:0] fsel2;

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   // Load-use hit: an ID source matches a load still inside its latency window.
   always_comb begin
      load_hit = 1'b0;
      for (int s = 2; s <= 1 + LOAD_LAT; s++) begin
         if (vld[s] && rd_en[s] && ld[s] &&
             ((id_rs1_en && (id_rs1 == rd[s])) || (id_rs2_en && (id_rs2 == rd[s]))))
            load_hit = 1'b1;
      end
   end

   // Priority: freeze > redirect_mem > redirect_ex > load-use stall > normal.
   assign take_mem = ~mem_wait & redirect_mem;
   assign take_ex  = ~mem_wait & ~redirect_mem & redirect_ex;
   assign lu_stall = ~mem_wait & ~redirect_mem & ~redirect_ex & id_valid & load_hit;
   assign bubble_i = take_mem | take_ex | lu_stall;
   // Front end moves on redirects too: IF/ID must be written to take the NOP.
   assign advance  = ~mem_wait & ~lu_stall;

   // Outputs are forced low while reset is asserted, without waiting for a clock.
   assign pc_write   = RST & advance;
   assign ifid_write = RST & advance;
   assign bubble     = RST & bubble_i;
   assign flush_ifid = RST & (take_mem | take_ex);
   assign flush_ex   = RST & take_mem;
   assign pc_sel     = !RST    ? 2'd0 :
                       take_mem ? 2'd2 :
                       take_ex  ? 2'd1 : 2'd0;
   assign fwd_sel1   = fsel1;
   assign fwd_sel2   = fsel2;
   assign stall_cnt  = stall_q;
   assign flush_cnt  = flush_q;

   // Bypass select: scan from the oldest slot down so the youngest match wins.
   always_comb begin
      fsel1 = '0;
      fsel2 = '0;
      for (int k = STAGES - 1; k >= 3; k--) begin
         if (vld[k] && rd_en[k] && !(ld[k] && (k <= 2 + LOAD_LAT))) begin
            if (rd[k] == rs1_p2) fsel1 = SEL_W'(k);
            if (rd[k] == rs2_p2) fsel2 = SEL_W'(k);
         end
      end
      if (!(RST && vld[2] && rs1_en_p2)) fsel1 = '0;
      if (!(RST && vld[2] && rs2_en_p2)) fsel2 = '0;
   end

   // Slot valid bits and counters; frozen pipe holds, only stall_q moves.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int s = 2; s < STAGES; s++) vld[s] <= 1'b0;
         stall_q <= '0;
         flush_q <= '0;
      end else if (mem_wait) begin
         stall_q <= sat_inc(stall_q);
      end else begin
         vld[2] <= id_valid & ~bubble_i;
         vld[3] <= vld[2] & ~take_mem;
         for (int s = 4; s < STAGES; s++) vld[s] <= vld[s-1];
         if (take_mem | take_ex) flush_q <= sat_inc(flush_q);
         if (lu_stall)           stall_q <= sat_inc(stall_q);
      end
   end

   // Slot payload shifts with the valid bits; it is meaningless while vld is low.
   always_ff @(posedge CLK) begin
      if (!mem_wait) begin
         rd[2]     <= id_rd;
         rd_en[2]  <= id_rd_en;
         ld[2]     <= id_is_load;
         rs1_p2    <= id_rs1;
         rs2_p2    <= id_rs2;
         rs1_en_p2 <= id_rs1_en;
         rs2_en_p2 <= id_rs2_en;
         for (int s = 3; s < STAGES; s++) begin
            rd[s]    <= rd[s-1];
            rd_en[s] <= rd_en[s-1];
            ld[s]    <= ld[s-1];
         end
      end
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised in-order pipeline control block for the 16-bit pipelined CPU.
- Replaces the fixed hazard-detect and forward logic and the scattered flush muxes of the 5-stage core.
- Tracks per-slot valid, destination, and load state in its own scoreboard.
- Generates PC/IF-ID write enables, bubble insertion, per-slot flushes, the PC source select, and EX operand bypass selects.
- Supports a configurable number of post-EX slots, register-id width and load latency, plus a whole-pipe memory-wait freeze and saturating stall/flush counters.

Parameters:
- STAGES, 5, number of pipeline slots including IF; slot 1 = IF/ID, 2 = ID/EX, 3..STAGES-1 = post-EX registers. Legal range 4..8.
- RA_W, 4, register-id width, covering general and special registers in one id space.
- LOAD_LAT, 1, number of post-EX slots a load occupies before its data is forwardable. Legal range 1..STAGES-4.
- SEL_W, 3, width of the bypass select. Must satisfy 2^SEL_W > STAGES-1.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_rs1, id_rs2  in  RA_W  source register ids of the ID instruction.
- id_rs1_en, id_rs2_en  in  1  the ID instruction reads that source.
- id_rd  in  RA_W  destination register id of the ID instruction.
- id_rd_en  in  1  the ID instruction writes id_rd.
- id_is_load  in  1  the ID instruction is a memory read.
- redirect_ex  in  1  jump resolved in EX (slot 2).
- redirect_mem  in  1  taken branch resolved in slot 3.
- mem_wait  in  1  memory/UART busy; freeze the whole pipe.
- pc_write  out  1  PC register load enable.
- pc_sel  out  2  PC source: 0 = PC+1, 1 = EX target, 2 = MEM target.
- ifid_write  out  1  IF/ID load enable.
- flush_ifid  out  1  load a NOP into IF/ID.
- bubble  out  1  zero the control fields entering ID/EX.
- flush_ex  out  1  squash the instruction leaving EX; slot 3 becomes invalid.
- fwd_sel1, fwd_sel2  out  SEL_W  EX operand source: 0 = ID/EX register file value, k = result held in slot k (3..STAGES-1).
- stall_cnt, flush_cnt  out  16  saturating performance counters.

Behaviour:
- Scoreboard per slot s in 2..STAGES-1 holds: v, rd, rd_en, ld. Slot 2 also holds rs1, rs1_en, rs2, rs2_en.
- Reset (RST=0):
  - All v, counters and outputs are 0.
  - pc_sel = 0, pc_write = 0, ifid_write = 0.
  - Reset takes effect immediately and is asynchronous.
  - Reset mid-stall or mid-flush discards all state.
- Freeze: mem_wait=1 overrides everything.
  - pc_write, ifid_write, bubble and all flushes are 0; the scoreboard holds.
  - stall_cnt increments once per frozen cycle.
  - Redirect inputs are ignored while frozen; they persist because their source slots are frozen.
- Priority when not frozen: redirect_mem > redirect_ex > load-use stall > normal.
- redirect_mem:
  - pc_sel = 2, pc_write = 1, flush_ifid = 1, bubble = 1, flush_ex = 1.
  - Next cycle slots 2 and 3 are invalid; flush_cnt += 1.
- redirect_ex:
  - pc_sel = 1, pc_write = 1, flush_ifid = 1, bubble = 1.
  - Next cycle slot 2 is invalid; flush_cnt += 1.
- Load-use stall: raised when id_valid, and an enabled ID source equals rd of a slot s in 2..1+LOAD_LAT with v, rd_en and ld set.
  - pc_write = 0, ifid_write = 0, bubble = 1; stall_cnt += 1.
  - Repeats each cycle until the condition clears. A load at LOAD_LAT=2 gives a 2-cycle stall.
- Normal:
  - pc_write = 1, ifid_write = 1, pc_sel = 0.
  - Slot 2 loads ID fields, with v = id_valid & ~bubble.
  - Each slot s+1 takes slot s; the last slot's content drops.
- Bypass, combinational from slot 2's sources:
  - fwd_selN = smallest k in 3..STAGES-1 such that slot k has v, rd_en, rd == rsN and is forwardable; otherwise 0.
  - Forwardable means not (ld and k ≤ 2+LOAD_LAT).
  - fwd_selN = 0 if slot 2 is invalid or rsN_en = 0.
- Counters saturate at 16'hFFFF and never wrap.
- There is no hardwired zero register; id 0 is forwarded like any other id.

Test Plan:
- Reset: RST low mid-run with slots valid -> all outputs 0 immediately; after release, first cycle pc_write=1, fwd_sel1/fwd_sel2=0.
- Back-to-back ALU RAW: ADD r3 then ADD r4,r3,r3 -> fwd_sel1 = fwd_sel2 = 3. With one independent instruction between -> fwd_sel1 = fwd_sel2 = 4.
- Load-use: LW r2 followed by ADD using r2 -> one cycle with pc_write=0, ifid_write=0, bubble=1, stall_cnt=1, then fwd_sel1 = 4. With LOAD_LAT=2, STAGES=6 -> 2 stall cycles, fwd_sel1 = 5.
- Redirect_ex and load-use in the same cycle -> pc_sel=1, flush_ifid=1, no stall, stall_cnt unchanged, flush_cnt=1.
- Redirect_mem and redirect_ex together -> pc_sel=2, flush_ex=1; next cycle slots 2 and 3 are invalid and fwd_sel1 = fwd_sel2 = 0.
- mem_wait high 3 cycles during load-use -> all enables 0, scoreboard unchanged, stall_cnt += 3. Preload 16'hFFFE, run 5 stalls -> stall_cnt = 16'hFFFF.
